pipelined_hybrid_adder: RTL and testbench

- Parametrised, pipelined successor to the team's 16-bit hybrid carry-lookahead/carry-select adder.
- Splits a WIDTH-bit add/subtract into STAGES equal segments of SEG_W bits.
  - Segment 0 uses carry-lookahead; every other segment uses carry-select.
  - One register stage per segment.
- Valid/ready streaming handshake with full backpressure.
- Sits between operand-producing datapath blocks and result consumers that run at clock rates the 16-bit combinational adder cannot meet.

---
 rtl/hybrid_adder_pkg.sv | 20 ++
 rtl/hybrid_seg_stage.sv | 132 +++++++++++++
 rtl/pipelined_hybrid_adder.sv | 93 +++++++++
 tb/tb_pipelined_hybrid_adder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hybrid_adder_pkg.sv
// rtl/hybrid_adder_pkg.sv - shared types, default sizes and stage-count helper for the hybrid adder
package hybrid_adder_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_mode_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG_W = 8;

    // Returns 0 for an illegal geometry so the top can refuse to elaborate.
    function automatic int calc_stages(input int width, input int seg_w);
        if (seg_w < 2 || seg_w > 16 || width < seg_w || (width % seg_w) != 0) begin
            return 0;
        end
        return width / seg_w;
    endfunction

endpackage

// File: rtl/hybrid_seg_stage.sv
// rtl/hybrid_seg_stage.sv - one registered adder segment (CLA or carry-select) with valid/ready; optional PIPELINED_HYBRID_ADDER_SAT_EN
module hybrid_seg_stage
    import hybrid_adder_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SEG_W   = DEF_SEG_W,
    parameter int IDX     = 0,
    parameter bit USE_CLA = 1'b1,
    parameter bit IS_LAST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_carry,
    input  logic             in_ovf,
`ifdef PIPELINED_HYBRID_ADDER_SAT_EN
    input  logic             in_sat,
    output logic             out_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam int LSB = IDX * SEG_W;
    localparam int MSB = LSB + SEG_W - 1;

    logic             valid_q;
    logic [SEG_W-1:0] seg_a;
    logic [SEG_W-1:0] seg_b;
    logic [SEG_W-1:0] seg_sum;
    logic             seg_co;
    logic             msb_cin;
    logic             raw_ovf;
    logic [WIDTH-1:0] nxt_a;
    logic [WIDTH-1:0] nxt_b;
    logic             nxt_ovf;

    assign seg_a     = in_a[LSB +: SEG_W];
    assign seg_b     = in_b[LSB +: SEG_W];
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;

    if (USE_CLA) begin : g_cla
        logic [SEG_W-1:0] gen;
        logic [SEG_W-1:0] prp;
        logic [SEG_W:0]   cy;

        assign gen = seg_a & seg_b;
        assign prp = seg_a ^ seg_b;

        // Flattened lookahead: every carry is a sum of generate/propagate products.
        always_comb begin
            logic term;
            logic prop;
            term  = 1'b0;
            prop  = 1'b0;
            cy    = '0;
            cy[0] = in_carry;
            for (int i = 0; i < SEG_W; i++) begin
                term = gen[i];
                prop = prp[i];
                for (int j = i - 1; j >= 0; j--) begin
                    term = term | (prop & gen[j]);
                    prop = prop & prp[j];
                end
                cy[i+1] = term | (prop & in_carry);
            end
        end

        assign seg_sum = prp ^ cy[SEG_W-1:0];
        assign seg_co  = cy[SEG_W];
    end else begin : g_csel
        logic [SEG_W:0] sum0;
        logic [SEG_W:0] sum1;

        assign sum0 = {1'b0, seg_a} + {1'b0, seg_b};
        assign sum1 = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_W{1'b0}}, 1'b1};
        assign {seg_co, seg_sum} = in_carry ? sum1 : sum0;
    end

    // Carry into the segment MSB recovered from the sum bit itself.
    assign msb_cin = seg_sum[SEG_W-1] ^ seg_a[SEG_W-1] ^ seg_b[SEG_W-1];
    assign raw_ovf = seg_co ^ msb_cin;

    // Splice the new sum segment in, drop the consumed B bits, resolve flags.
    always_comb begin
        nxt_a                = in_a;
        nxt_a[LSB +: SEG_W]  = seg_sum;
        nxt_b                = in_b;
        nxt_b[MSB:0]         = '0;
        nxt_ovf              = IS_LAST ? raw_ovf : in_ovf;
`ifdef PIPELINED_HYBRID_ADDER_SAT_EN
        if (IS_LAST && in_sat && raw_ovf) begin
            nxt_a = (seg_a[SEG_W-1] | seg_b[SEG_W-1]) ? {1'b1, {(WIDTH-1){1'b0}}}
                                                      : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    // Stage register: loads when empty or downstream drains, holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_carry <= 1'b0;
            out_ovf   <= 1'b0;
`ifdef PIPELINED_HYBRID_ADDER_SAT_EN
            out_sat   <= 1'b0;
`endif
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                out_a     <= nxt_a;
                out_b     <= nxt_b;
                out_carry <= seg_co;
                out_ovf   <= nxt_ovf;
`ifdef PIPELINED_HYBRID_ADDER_SAT_EN
                out_sat   <= in_sat;
`endif
            end
        end
    end

endmodule

// File: rtl/pipelined_hybrid_adder.sv
// rtl/pipelined_hybrid_adder.sv - pipelined segmented add/subtract with valid/ready; optional PIPELINED_HYBRID_ADDER_SAT_EN
module pipelined_hybrid_adder
    import hybrid_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG_W = DEF_SEG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic             in_sub,
`ifdef PIPELINED_HYBRID_ADDER_SAT_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             out_ovf
);

    localparam int STAGES = calc_stages(WIDTH, SEG_W);

    if (STAGES == 0) begin : g_bad_cfg
        $error("pipelined_hybrid_adder: WIDTH must be a multiple of SEG_W and SEG_W in 2..16");
    end

    op_mode_e         op;
    logic [WIDTH-1:0] a_s   [STAGES+1];
    logic [WIDTH-1:0] b_s   [STAGES+1];
    logic             c_s   [STAGES+1];
    logic             ovf_s [STAGES+1];
    logic             v_s   [STAGES+1];
    logic             r_s   [STAGES+1];
    logic             unused_tail;

    // Subtract folds into add: invert B and force the carry-in at capture.
    assign op       = in_sub ? OP_SUB : OP_ADD;
    assign a_s[0]   = in_a;
    assign b_s[0]   = (op == OP_SUB) ? ~in_b : in_b;
    assign c_s[0]   = (op == OP_SUB) ? 1'b1 : in_ci;
    assign ovf_s[0] = 1'b0;
    assign v_s[0]   = in_valid;
    assign in_ready = r_s[0];
    assign r_s[STAGES] = out_ready;

`ifdef PIPELINED_HYBRID_ADDER_SAT_EN
    logic sat_s [STAGES+1];
    assign sat_s[0]    = in_sat;
    assign unused_tail = (^b_s[STAGES]) ^ sat_s[STAGES];
`else
    assign unused_tail = ^b_s[STAGES];
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        hybrid_seg_stage #(
            .WIDTH   (WIDTH),
            .SEG_W   (SEG_W),
            .IDX     (k),
            .USE_CLA (k == 0),
            .IS_LAST (k == STAGES - 1)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (v_s[k]),
            .in_ready  (r_s[k]),
            .in_a      (a_s[k]),
            .in_b      (b_s[k]),
            .in_carry  (c_s[k]),
            .in_ovf    (ovf_s[k]),
`ifdef PIPELINED_HYBRID_ADDER_SAT_EN
            .in_sat    (sat_s[k]),
            .out_sat   (sat_s[k+1]),
`endif
            .out_valid (v_s[k+1]),
            .out_ready (r_s[k+1]),
            .out_a     (a_s[k+1]),
            .out_b     (b_s[k+1]),
            .out_carry (c_s[k+1]),
            .out_ovf   (ovf_s[k+1])
        );
    end

    assign out_valid = v_s[STAGES];
    assign out_sum   = a_s[STAGES];
    assign out_co    = c_s[STAGES];
    assign out_ovf   = ovf_s[STAGES];

endmodule

// File: tb/tb_pipelined_hybrid_adder.sv
// tb/tb_pipelined_hybrid_adder.sv - directed and scoreboard checks for pipelined_hybrid_adder (WIDTH=16, SEG_W=4)
module tb_pipelined_hybrid_adder;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sub;
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ci = 1'b0;
    logic         in_sub = 1'b0;
    logic         in_sat = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_co;
    logic         out_ovf;

    int           checks = 0;
    int           errors = 0;
    int           acc_cnt = 0;
    int           out_cnt = 0;
    int           cyc = 0;
    int           first_out = -1;
    int           last_out = -1;
    int           unexpected = 0;
    logic         acc_now = 1'b0;
    logic [17:0]  exp_q [$];
    vec_t         vecs [10];

    pipelined_hybrid_adder #(.WIDTH(W), .SEG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .in_sub    (in_sub),
`ifdef PIPELINED_HYBRID_ADDER_SAT_EN
        .in_sat    (in_sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result packed as {co, ovf, sum}.
    function automatic logic [17:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic ci, input logic sub, input logic sat);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         ovf;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, (sub ? 1'b1 : ci)};
        s    = full[W-1:0];
        ovf  = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
`ifdef PIPELINED_HYBRID_ADDER_SAT_EN
        if (sat && ovf) s = a[W-1] ? 16'h8000 : 16'h7FFF;
`else
        if (sat) s = s;
`endif
        return {full[W], ovf, s};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_beat();
        in_a   = 16'($urandom);
        in_b   = 16'($urandom);
        in_ci  = 1'($urandom);
        in_sub = 1'($urandom);
        in_sat = 1'b0;
    endtask

    // One clock: sample handshakes mid-cycle, score accepts and results, then advance.
    task automatic cycle();
        logic [17:0] e;
        #3;
        acc_now = in_valid && in_ready;
        if (acc_now) begin
            exp_q.push_back(ref_model(in_a, in_b, in_ci, in_sub, in_sat));
            acc_cnt++;
        end
        if (out_valid && out_ready) begin
            out_cnt++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            if (exp_q.size() == 0) begin
                unexpected++;
            end else begin
                e = exp_q.pop_front();
                check("stream_result", {14'b0, out_co, out_ovf, out_sum}, {14'b0, e});
            end
        end
        step();
        cyc++;
    endtask

    // Single isolated beat; reports the result and accept-to-valid latency.
    task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                            input logic sub, input logic sat, output logic [17:0] got, output int lat);
        in_a = a; in_b = b; in_ci = ci; in_sub = sub; in_sat = sat;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        got = {out_co, out_ovf, out_sum};
        step();
    endtask

    initial begin
        logic [17:0] got;
        logic [17:0] hold;
        logic        seen;
        int          lat;
        int          n;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[6] = '{16'h000F, 16'h0001, 1'b1, 1'b0, 16'h0011, 1'b0, 1'b0};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[9] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_out_sum", {16'b0, out_sum}, 32'd0);
        check("reset_out_co", {31'b0, out_co}, 32'd0);
        check("reset_out_ovf", {31'b0, out_ovf}, 32'd0);
        check("reset_in_ready", {31'b0, in_ready}, 32'd1);

        // Directed single-beat vectors with latency.
        for (int i = 0; i < 10; i++) begin
            send_one(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub, 1'b0, got, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("vec%0d_sum", i), {16'b0, got[15:0]}, {16'b0, vecs[i].sum});
            check($sformatf("vec%0d_co", i), {31'b0, got[17]}, {31'b0, vecs[i].co});
            check($sformatf("vec%0d_ovf", i), {31'b0, got[16]}, {31'b0, vecs[i].ovf});
        end

        // Back-to-back stream of 20 beats.
        acc_cnt = 0; out_cnt = 0; first_out = -1; unexpected = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            randomize_beat();
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            cycle();
            n++;
        end
        check("stream_accepted", 32'(acc_cnt), 32'd20);
        check("stream_results", 32'(out_cnt), 32'd20);
        check("stream_one_per_cycle", 32'(last_out - first_out), 32'd19);
        check("stream_unexpected", 32'(unexpected), 32'd0);

        // Backpressure: 10 stalled cycles fill all four stages, then drain+accept together.
        acc_cnt = 0; out_cnt = 0; unexpected = 0; seen = 1'b0; hold = '0;
        out_ready = 1'b0;
        randomize_beat();
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (acc_now) randomize_beat();
            cycle();
            if (out_valid && !seen) begin
                seen = 1'b1;
                hold = {out_co, out_ovf, out_sum};
            end
        end
        check("bp_accepted_while_stalled", 32'(acc_cnt), 32'd4);
        check("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
        check("bp_out_valid_held", {31'b0, out_valid}, 32'd1);
        check("bp_output_stable", {14'b0, out_co, out_ovf, out_sum}, {14'b0, hold});
        if (acc_now) randomize_beat();
        out_ready = 1'b1;
        cycle();
        check("bp_release_accept", {31'b0, acc_now}, 32'd1);
        check("bp_release_drain", 32'(out_cnt), 32'd1);
        in_valid = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            cycle();
            n++;
        end
        check("bp_total_accepted", 32'(acc_cnt), 32'd5);
        check("bp_total_results", 32'(out_cnt), 32'd5);
        check("bp_unexpected", 32'(unexpected), 32'd0);

        // Reset with three beats in flight.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_beat();
            in_valid = 1'b1;
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("pre_reset_out_valid", {31'b0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_async_out_valid", {31'b0, out_valid}, 32'd0);
        check("reset_async_out_sum", {16'b0, out_sum}, 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        out_cnt = 0; unexpected = 0;
        for (int i = 0; i < 10; i++) cycle();
        check("post_reset_stale_results", 32'(out_cnt), 32'd0);
        check("post_reset_in_ready", {31'b0, in_ready}, 32'd1);

`ifdef PIPELINED_HYBRID_ADDER_SAT_EN
        // Saturation corner cases.
        send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, got, lat);
        check("sat_pos_sum", {16'b0, got[15:0]}, 32'h7FFF);
        check("sat_pos_ovf", {31'b0, got[16]}, 32'd1);
        send_one(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b1, got, lat);
        check("sat_neg_sum", {16'b0, got[15:0]}, 32'h8000);
        check("sat_neg_ovf", {31'b0, got[16]}, 32'd1);
        send_one(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, got, lat);
        check("sat_sub_sum", {16'b0, got[15:0]}, 32'h8000);
        send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, got, lat);
        check("sat_off_sum", {16'b0, got[15:0]}, 32'h8000);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
